// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, prefetch sizing constants and entry type for the instruction prefetcher.
package tinyriscv_pkg;

    localparam int unsigned MemAddrBus       = 32;
    localparam int unsigned MemBus           = 32;
    localparam int unsigned PrefetchDepth    = 4;
    localparam int unsigned PrefetchMaxOutst = 2;

    typedef struct packed {
        logic [MemAddrBus-1:0] addr;
        logic [MemBus-1:0]     data;
    } pf_entry_t;

    // Sequential word step; wraps modulo 2^32.
    function automatic logic [MemAddrBus-1:0] next_word(input logic [MemAddrBus-1:0] addr);
        return addr + MemAddrBus'(4);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular FIFO holding prefetched instruction words; flush empties it in one cycle.
module prefetch_fifo
    import tinyriscv_pkg::*;
#(
    parameter int unsigned DEPTH = PrefetchDepth,
    parameter int unsigned WIDTH = MemBus,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // The credit check upstream must make this unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && !flush_i && count_q == CntW'(DEPTH)))
        else $error("prefetch_fifo: push into full FIFO");

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher with flush-on-miss and in-flight response dropping.
// Optional perf counters (perf_hit_o / perf_miss_o) when INST_PREFETCH_PERF_EN is defined.
module inst_prefetch
    import tinyriscv_pkg::*;
#(
    parameter int unsigned           DEPTH      = PrefetchDepth,
    parameter int unsigned           MAX_OUTST  = PrefetchMaxOutst,
    parameter logic [MemAddrBus-1:0] RESET_ADDR = 32'h0
) (
`ifdef INST_PREFETCH_PERF_EN
    output logic [31:0]           perf_hit_o,
    output logic [31:0]           perf_miss_o,
`endif
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  core_req_i,
    input  logic [MemAddrBus-1:0] core_addr_i,
    output logic [MemBus-1:0]     core_data_o,
    output logic                  core_ready_o,
    output logic                  mem_req_o,
    output logic [MemAddrBus-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [MemBus-1:0]     mem_rdata_i
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTST + 1);

    logic [MemAddrBus-1:0] fetch_addr_q, fetch_addr_d;
    logic [MemAddrBus-1:0] head_addr_q, head_addr_d;
    logic [OutW-1:0]       outst_q, outst_d;
    logic [OutW-1:0]       drop_q, drop_d;
    logic [CntW-1:0]       count;
    logic [MemBus-1:0]     head_data;
    logic                  hit, miss, credit_ok, grant, push;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MemBus)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (hit),
        .flush_i (miss),
        .wdata_i (mem_rdata_i),
        .rdata_o (head_data),
        .count_o (count)
    );

    always_comb begin
        hit       = core_req_i && (core_addr_i == head_addr_q) && (count != '0);
        miss      = core_req_i && (core_addr_i != head_addr_q);
        credit_ok = (32'(count) + 32'(outst_q) + 32'(drop_q) < DEPTH) &&
                    (32'(outst_q) + 32'(drop_q) < MAX_OUTST);
        // Gated by reset so the bus sees no request while held in reset.
        mem_req_o    = rst_ni && !miss && credit_ok;
        mem_addr_o   = fetch_addr_q;
        grant        = mem_req_o && mem_gnt_i;
        push         = mem_rvalid_i && !miss && (drop_q == '0);
        core_ready_o = hit;
        core_data_o  = hit ? head_data : '0;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        head_addr_d  = head_addr_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        if (miss) begin
            fetch_addr_d = core_addr_i;
            head_addr_d  = core_addr_i;
            // Everything still in flight, less the response consumed right now, becomes stale.
            drop_d  = OutW'(32'(drop_q) + 32'(outst_q) + 32'(grant) - 32'(mem_rvalid_i));
            outst_d = '0;
        end else begin
            if (grant) fetch_addr_d = next_word(fetch_addr_q);
            if (hit)   head_addr_d  = next_word(head_addr_q);
            if (mem_rvalid_i && drop_q != '0) drop_d = drop_q - OutW'(1);
            outst_d = OutW'(32'(outst_q) + 32'(grant) - 32'(push));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= RESET_ADDR;
            head_addr_q  <= RESET_ADDR;
            outst_q      <= '0;
            drop_q       <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            head_addr_q  <= head_addr_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
        end
    end

`ifdef INST_PREFETCH_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (hit)  perf_hit_q  <= perf_hit_q + 32'd1;
            if (miss) perf_miss_q <= perf_miss_q + 32'd1;
        end
    end

    assign perf_hit_o  = perf_hit_q;
    assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: vector table plus hand-written flush/drop sequences.
module tb_inst_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_data_o;
    logic        core_ready_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef INST_PREFETCH_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_grants = 0;
    logic        resp_en  = 1'b1;
    logic [31:0] pend_q[$];

    always #5 clk_i = ~clk_i;

    inst_prefetch #(
        .DEPTH      (4),
        .MAX_OUTST  (2),
        .RESET_ADDR (32'h0)
    ) u_dut (
`ifdef INST_PREFETCH_PERF_EN
        .perf_hit_o   (perf_hit),
        .perf_miss_o  (perf_miss),
`endif
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_addr_i  (core_addr_i),
        .core_data_o  (core_data_o),
        .core_ready_o (core_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Memory model: records grants, answers one cycle later in order while resp_en is set.
    task automatic tick();
        #1;
        if (mem_req_o && mem_gnt_i) begin
            pend_q.push_back(mem_addr_o);
            n_grants++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (resp_en && pend_q.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word(pend_q.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic gnt);
        core_req_i  = req;
        core_addr_i = addr;
        mem_gnt_i   = gnt;
        #1;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        core_req_i   = 1'b0;
        core_addr_i  = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        resp_en      = 1'b1;
        pend_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic chk_core(input string name, input logic rdy, input logic [31:0] data);
        chk({name, " ready"}, 32'(core_ready_o), 32'(rdy));
        chk({name, " data"}, core_data_o, data);
    endtask

    task automatic chk_mem(input string name, input logic req, input logic [31:0] addr);
        chk({name, " mem_req"}, 32'(mem_req_o), 32'(req));
        if (req) chk({name, " mem_addr"}, mem_addr_o, addr);
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        gnt;
        logic        exp_ready;
        logic [31:0] exp_data;
        logic        exp_mreq;
        logic [31:0] exp_maddr;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    function automatic vec_t mk(input string n, input logic r, input logic q, input logic [31:0] a,
                                input logic rdy, input logic [31:0] d, input logic mr,
                                input logic [31:0] ma);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.addr = a; v.gnt = 1'b1;
        v.exp_ready = rdy; v.exp_data = d; v.exp_mreq = mr; v.exp_maddr = ma;
        return v;
    endfunction

    initial begin
        // Cold start: request at cycle 1, push at 2, first hit at 3, then one per cycle.
        vec[0]  = mk("cold0", 1, 1, 32'h0,  0, 32'h0,                 1, 32'h0);
        vec[1]  = mk("cold1", 0, 1, 32'h0,  0, 32'h0,                 1, 32'h4);
        vec[2]  = mk("cold2", 0, 1, 32'h0,  1, 32'h0 ^ 32'hA5A5_5A5A,  1, 32'h8);
        vec[3]  = mk("cold3", 0, 1, 32'h4,  1, 32'h4 ^ 32'hA5A5_5A5A,  1, 32'hC);
        vec[4]  = mk("cold4", 0, 1, 32'h8,  1, 32'h8 ^ 32'hA5A5_5A5A,  1, 32'h10);
        vec[5]  = mk("cold5", 0, 1, 32'hC,  1, 32'hC ^ 32'hA5A5_5A5A,  1, 32'h14);
        vec[6]  = mk("cold6", 0, 1, 32'h10, 1, 32'h10 ^ 32'hA5A5_5A5A, 1, 32'h18);
        // Jump to the top of the address space; the miss cycle withholds the request.
        vec[7]  = mk("wrap0", 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 0, 32'h0);
        vec[8]  = mk("wrap1", 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'hFFFF_FFF8);
        vec[9]  = mk("wrap2", 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'hFFFF_FFFC);
        vec[10] = mk("wrap3", 0, 1, 32'hFFFF_FFF8, 1, 32'h5A5A_A5A2, 1, 32'h0);
        vec[11] = mk("wrap4", 0, 1, 32'hFFFF_FFFC, 1, 32'h5A5A_A5A6, 1, 32'h4);
        vec[12] = mk("wrap5", 0, 1, 32'h0, 1, 32'hA5A5_5A5A, 1, 32'h8);
        vec[13] = mk("wrap6", 0, 1, 32'h4, 1, 32'hA5A5_5A5E, 1, 32'hC);

        // Outputs while held in reset.
        rst_ni = 1'b0; core_req_i = 1'b0; core_addr_i = '0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1;
        chk("reset ready", 32'(core_ready_o), 32'h0);
        chk("reset data", core_data_o, 32'h0);
        chk("reset mem_req", 32'(mem_req_o), 32'h0);
        chk("reset mem_addr", mem_addr_o, 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vec[i].rst) do_reset();
            drive(vec[i].req, vec[i].addr, vec[i].gnt);
            chk_core(vec[i].name, vec[i].exp_ready, vec[i].exp_data);
            chk_mem(vec[i].name, vec[i].exp_mreq, vec[i].exp_maddr);
            tick();
        end

        // Back-pressure: exactly four words fetched, then the credit check stops requests.
        do_reset();
        n_grants = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            tick();
        end
        chk("bp grants", 32'(n_grants), 32'd4);
        drive(1'b0, 32'h0, 1'b1);
        chk("bp mem_req idle", 32'(mem_req_o), 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'(4 * k), 1'b1);
            chk_core($sformatf("bp drain%0d", k), 1'b1, word(32'(4 * k)));
            chk($sformatf("bp drain%0d mem_req", k), 32'(mem_req_o), 32'(k != 0));
            tick();
        end

        // Jump with two responses in flight: both dropped, restart at 0x100.
        do_reset();
        resp_en = 1'b0;
        drive(1'b0, 32'h0, 1'b1); chk_mem("jmp c1", 1'b1, 32'h0); tick();
        drive(1'b0, 32'h0, 1'b1); chk_mem("jmp c2", 1'b1, 32'h4); tick();
        resp_en = 1'b1;
        drive(1'b1, 32'h100, 1'b1); chk_core("jmp c3", 1'b0, 32'h0); chk_mem("jmp c3", 1'b0, 0);
        tick();
        drive(1'b1, 32'h100, 1'b1); chk_core("jmp c4", 1'b0, 32'h0); chk_mem("jmp c4", 1'b0, 0);
        chk("jmp c4 mem_addr", mem_addr_o, 32'h100);
        tick();
        drive(1'b1, 32'h100, 1'b1); chk_core("jmp c5", 1'b0, 32'h0);
        chk_mem("jmp c5", 1'b1, 32'h100); tick();
        drive(1'b1, 32'h100, 1'b1); chk_core("jmp c6", 1'b0, 32'h0);
        chk_mem("jmp c6", 1'b1, 32'h104); tick();
        drive(1'b1, 32'h100, 1'b1); chk_core("jmp c7", 1'b1, word(32'h100)); tick();

        // Miss in the same cycle as a response, with a later grant still outstanding.
        do_reset();
        resp_en = 1'b0;
        drive(1'b0, 32'h0, 1'b1); tick();
        resp_en = 1'b1;
        drive(1'b0, 32'h0, 1'b1); chk_mem("mrv c2", 1'b1, 32'h4); tick();
        chk("mrv c3 rvalid present", 32'(mem_rvalid_i), 32'h1);
        drive(1'b1, 32'h200, 1'b1); chk_core("mrv c3", 1'b0, 32'h0); chk_mem("mrv c3", 1'b0, 0);
        tick();
        drive(1'b1, 32'h200, 1'b1); chk_core("mrv c4", 1'b0, 32'h0);
        chk_mem("mrv c4", 1'b1, 32'h200); tick();
        drive(1'b1, 32'h200, 1'b1); chk_core("mrv c5", 1'b0, 32'h0);
        chk_mem("mrv c5", 1'b1, 32'h204); tick();
        drive(1'b1, 32'h200, 1'b1); chk_core("mrv c6", 1'b1, word(32'h200)); tick();

`ifdef INST_PREFETCH_PERF_EN
        begin
            int          h;
            logic [31:0] pc;
            do_reset();
            h  = 0;
            pc = 32'h0;
            for (int c = 0; c < 100 && h < 10; c++) begin
                drive(1'b1, pc, 1'b1);
                if (core_ready_o) begin
                    h++;
                    pc = (h == 5) ? 32'h40 : pc + 32'd4;
                end
                tick();
            end
            chk("perf hits seen", 32'(h), 32'd10);
            drive(1'b1, 32'h80, 1'b1); tick();
            drive(1'b0, 32'h0, 1'b1);
            chk("perf_hit_o", perf_hit, 32'd10);
            chk("perf_miss_o", perf_miss, 32'd2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
